// File: rtl/v_avg_pkg.sv
// Shared types and width helpers for the frame-average block.
package v_avg_pkg;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      DIVIDE = 2'd1,
      SEND   = 2'd2
   } v_state_t;

   // Pixel counter must reach FRAME_PIXELS itself.
   function automatic int cnt_w(input int frame_pixels);
      return $clog2(frame_pixels + 1);
   endfunction

   // Sum of FRAME_PIXELS 8-bit pixels never overflows 8+CNT_W bits.
   function automatic int sum_w(input int frame_pixels);
      return 8 + cnt_w(frame_pixels);
   endfunction

endpackage

// File: rtl/v_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, fixed SUM_W-cycle latency.
// The dividend shifts out of q_reg MSB-first while quotient bits shift in at the LSB.
module v_divider #(
   parameter int CNT_W = 3,
   parameter int SUM_W = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [SUM_W-1:0] dividend,
   input  logic [CNT_W-1:0] divisor,
   output logic             done,
   output logic [SUM_W-1:0] quotient
);

   localparam int ITER_W = $clog2(SUM_W + 1);

   logic [SUM_W-1:0]  q_reg;
   logic [CNT_W-1:0]  rem_reg;
   logic [CNT_W-1:0]  dvs_reg;
   logic [ITER_W-1:0] iter_reg;
   logic              busy_reg;
   logic              done_reg;

   logic [CNT_W:0]    trial;
   logic              fits;
   logic [CNT_W-1:0]  rem_next;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      trial    = {rem_reg, q_reg[SUM_W-1]};
      fits     = (trial >= {1'b0, dvs_reg});
      rem_next = trial[CNT_W-1:0];
      if (fits) begin
         rem_next = CNT_W'(trial - {1'b0, dvs_reg});
      end
   end

   // Load on start, then iterate SUM_W times and pulse done for one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_reg    <= '0;
         rem_reg  <= '0;
         dvs_reg  <= '0;
         iter_reg <= '0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (start) begin
            q_reg    <= dividend;
            rem_reg  <= '0;
            dvs_reg  <= divisor;
            iter_reg <= ITER_W'(SUM_W);
            busy_reg <= 1'b1;
         end else if (busy_reg) begin
            q_reg    <= {q_reg[SUM_W-2:0], fits};
            rem_reg  <= rem_next;
            iter_reg <= iter_reg - ITER_W'(1);
            if (iter_reg == ITER_W'(1)) begin
               busy_reg <= 1'b0;
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign done     = done_reg;
   assign quotient = q_reg;

endmodule

// File: rtl/v_average.sv
// Frame mean brightness: accumulate FRAME_PIXELS pixels, divide, hand result downstream.
module v_average
   import v_avg_pkg::*;
#(
   parameter int FRAME_PIXELS = 76800
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pixel_v_in,
   input  logic       recv_req,
   output logic       recv_ack,
   output logic [7:0] avg_v_out,
   output logic       send_req,
   input  logic       send_ack
);

   localparam int CNT_W = cnt_w(FRAME_PIXELS);
   localparam int SUM_W = sum_w(FRAME_PIXELS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS - 1);
   localparam logic [CNT_W-1:0] DIVISOR  = CNT_W'(FRAME_PIXELS);

   v_state_t         state_reg, state_next;
   logic [SUM_W-1:0] sum_reg, sum_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [7:0]       avg_reg, avg_next;
   logic             send_req_reg, send_req_next;
   logic             recv_ack_reg, recv_ack_next;

   logic             div_start;
   logic             div_done;
   logic [SUM_W-1:0] quotient;
   logic             unused_quotient_hi;

   // The sum bound guarantees the quotient fits in 8 bits; upper bits are always zero.
   assign unused_quotient_hi = ^quotient[SUM_W-1:8];

   // The divider is launched on the final pixel edge with the sum including that pixel,
   // so the result lands SUM_W+1 edges after the last transfer.
   v_divider #(
      .CNT_W(CNT_W),
      .SUM_W(SUM_W)
   ) u_divider (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .dividend (sum_next),
      .divisor  (DIVISOR),
      .done     (div_done),
      .quotient (quotient)
   );

   // Next-state and datapath updates for the ACCUM/DIVIDE/SEND sequence.
   always_comb begin
      state_next    = state_reg;
      sum_next      = sum_reg;
      count_next    = count_reg;
      avg_next      = avg_reg;
      send_req_next = send_req_reg;
      div_start     = 1'b0;
      case (state_reg)
         ACCUM: begin
            if (recv_req && recv_ack_reg) begin
               sum_next = sum_reg + SUM_W'(pixel_v_in);
               if (count_reg == LAST_CNT) begin
                  count_next = '0;
                  div_start  = 1'b1;
                  state_next = DIVIDE;
               end else begin
                  count_next = count_reg + CNT_W'(1);
               end
            end
         end
         DIVIDE: begin
            if (div_done) begin
               avg_next      = quotient[7:0];
               send_req_next = 1'b1;
               state_next    = SEND;
            end
         end
         SEND: begin
            if (send_req_reg && send_ack) begin
               send_req_next = 1'b0;
               sum_next      = '0;
               state_next    = ACCUM;
            end
         end
         default: begin
            state_next = ACCUM;
         end
      endcase
      recv_ack_next = (state_next == ACCUM);
   end

   // State register; reset drops the partial frame and any pending result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= ACCUM;
         sum_reg      <= '0;
         count_reg    <= '0;
         avg_reg      <= '0;
         send_req_reg <= 1'b0;
         recv_ack_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         sum_reg      <= sum_next;
         count_reg    <= count_next;
         avg_reg      <= avg_next;
         send_req_reg <= send_req_next;
         recv_ack_reg <= recv_ack_next;
      end
   end

   assign recv_ack  = recv_ack_reg;
   assign avg_v_out = avg_reg;
   assign send_req  = send_req_reg;

endmodule

// File: tb/tb_v_average.sv
// Scoreboard bench for v_average: three instances (FRAME_PIXELS 4, 3, 1).
module tb_v_average;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] pix;
   logic       recv_req [3];
   logic       send_ack [3];
   logic       recv_ack [3];
   logic       send_req [3];
   logic [7:0] avg      [3];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ack_mode = 0;   // dut0 send_ack: 0 always high, 1 held low, 2 random
   int exp_q0[$];
   int exp_q1[$];
   int exp_q2[$];
   int last_xfer [3];
   logic prev_sr [3];
   int mon_sz;
   int mon_exp;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   v_average #(.FRAME_PIXELS(4)) dut0 (
      .clk(clk), .reset(reset), .pixel_v_in(pix), .recv_req(recv_req[0]),
      .recv_ack(recv_ack[0]), .avg_v_out(avg[0]), .send_req(send_req[0]),
      .send_ack(send_ack[0]));
   v_average #(.FRAME_PIXELS(3)) dut1 (
      .clk(clk), .reset(reset), .pixel_v_in(pix), .recv_req(recv_req[1]),
      .recv_ack(recv_ack[1]), .avg_v_out(avg[1]), .send_req(send_req[1]),
      .send_ack(send_ack[1]));
   v_average #(.FRAME_PIXELS(1)) dut2 (
      .clk(clk), .reset(reset), .pixel_v_in(pix), .recv_req(recv_req[2]),
      .recv_ack(recv_ack[2]), .avg_v_out(avg[2]), .send_req(send_req[2]),
      .send_ack(send_ack[2]));

   // SUM_W+1 per instance: FP=4 -> 12, FP=3 -> 11, FP=1 -> 10
   function automatic int lat_of(input int k);
      case (k)
         0:       return 12;
         1:       return 11;
         default: return 10;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input int k, input int v);
      case (k)
         0:       exp_q0.push_back(v);
         1:       exp_q1.push_back(v);
         default: exp_q2.push_back(v);
      endcase
   endtask

   function automatic int q_size(input int k);
      case (k)
         0:       return exp_q0.size();
         1:       return exp_q1.size();
         default: return exp_q2.size();
      endcase
   endfunction

   // Called at a negedge; returns at the negedge following the transfer edge.
   task automatic push_pixel(input int k, input logic [7:0] v, input int gap);
      int n;
      for (int g = 0; g < gap; g++) @(negedge clk);
      pix = v;
      recv_req[k] = 1'b1;
      n = 0;
      while (!recv_ack[k]) begin
         @(negedge clk);
         n++;
         if (n > 2000) begin
            total++;
            bad++;
            $display("FAIL recv_timeout dut%0d: got no recv_ack required recv_ack=1", k);
            break;
         end
      end
      @(negedge clk);
      last_xfer[k] = cyc;
      recv_req[k] = 1'b0;
   endtask

   task automatic wait_idle(input int k);
      int n;
      n = 0;
      while ((q_size(k) != 0 || send_req[k]) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         total++;
         bad++;
         $display("FAIL idle_timeout dut%0d: got pending=%0d required 0", k, q_size(k));
      end
   endtask

   // Drive send_ack for all instances.
   initial begin
      for (int k = 0; k < 3; k++) send_ack[k] = 1'b1;
      forever begin
         @(negedge clk);
         case (ack_mode)
            0:       send_ack[0] = 1'b1;
            1:       send_ack[0] = 1'b0;
            default: send_ack[0] = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: on every send_req rise, pop the expected mean and check value and latency.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (reset && send_req[k] && !prev_sr[k]) begin
            mon_sz = q_size(k);
            if (mon_sz == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result dut%0d: got avg=%0d required no result", k, avg[k]);
            end else begin
               case (k)
                  0:       mon_exp = exp_q0.pop_front();
                  1:       mon_exp = exp_q1.pop_front();
                  default: mon_exp = exp_q2.pop_front();
               endcase
               check($sformatf("avg_dut%0d", k), int'(avg[k]), mon_exp);
               check($sformatf("latency_dut%0d", k), cyc - last_xfer[k], lat_of(k));
            end
         end
         prev_sr[k] <= send_req[k];
      end
   end

   initial begin
      int frame [4];
      int s;
      reset = 1'b0;
      pix = '0;
      for (int k = 0; k < 3; k++) begin
         recv_req[k] = 1'b0;
         last_xfer[k] = 0;
         prev_sr[k] = 1'b0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_recv_ack", int'(recv_ack[0]), 0);
      check("rst_send_req", int'(send_req[0]), 0);
      check("rst_avg", int'(avg[0]), 0);
      reset = 1'b1;
      #1 check("recv_ack_before_edge", int'(recv_ack[0]), 0);
      @(negedge clk);
      check("recv_ack_after_rst_dut0", int'(recv_ack[0]), 1);
      check("recv_ack_after_rst_dut1", int'(recv_ack[1]), 1);
      check("recv_ack_after_rst_dut2", int'(recv_ack[2]), 1);

      // 10,20,30,41 -> 101/4 = 25
      push_exp(0, 25);
      push_pixel(0, 8'd10, 0);
      push_pixel(0, 8'd20, 0);
      push_pixel(0, 8'd30, 0);
      push_pixel(0, 8'd41, 0);
      wait_idle(0);

      // 255 x4 -> 255, then 0 x4 -> 0; 255 held until the second result
      push_exp(0, 255);
      for (int i = 0; i < 4; i++) push_pixel(0, 8'd255, 0);
      wait_idle(0);
      push_exp(0, 0);
      push_pixel(0, 8'd0, 0);
      push_pixel(0, 8'd0, 1);
      check("avg_held_255", int'(avg[0]), 255);
      push_pixel(0, 8'd0, 0);
      push_pixel(0, 8'd0, 0);
      wait_idle(0);
      check("avg_kept_after_xfer", int'(avg[0]), 0);

      // send_ack low during SEND with recv_req high: nothing moves, no pixel counted
      ack_mode = 1;
      push_exp(0, 2);
      push_pixel(0, 8'd1, 0);
      push_pixel(0, 8'd2, 0);
      push_pixel(0, 8'd3, 0);
      push_pixel(0, 8'd4, 0);
      for (int n = 0; n < 100 && !send_req[0]; n++) @(negedge clk);
      pix = 8'd99;
      recv_req[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("stall_avg", int'(avg[0]), 2);
         check("stall_send_req", int'(send_req[0]), 1);
         check("stall_recv_ack", int'(recv_ack[0]), 0);
      end
      push_exp(0, 99);
      ack_mode = 0;
      for (int i = 0; i < 4; i++) push_pixel(0, 8'd99, 0);
      wait_idle(0);

      // Reset mid-frame: two pixels discarded, then 8,8,8,8 -> 8
      push_pixel(0, 8'd100, 0);
      push_pixel(0, 8'd100, 0);
      reset = 1'b0;
      #1;
      check("async_rst_avg", int'(avg[0]), 0);
      check("async_rst_send_req", int'(send_req[0]), 0);
      check("async_rst_recv_ack", int'(recv_ack[0]), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      push_exp(0, 8);
      for (int i = 0; i < 4; i++) push_pixel(0, 8'd8, 0);
      wait_idle(0);

      // Reset during DIVIDE: no result may appear for that frame
      for (int i = 0; i < 4; i++) push_pixel(0, 8'd50, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1 check("div_rst_send_req", int'(send_req[0]), 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      push_exp(0, 7);
      for (int i = 0; i < 4; i++) push_pixel(0, 8'd7, 0);
      wait_idle(0);

      // FRAME_PIXELS=3: 1,1,2 -> 1; 2,2,3 -> 2
      push_exp(1, 1);
      push_pixel(1, 8'd1, 0);
      push_pixel(1, 8'd1, 0);
      push_pixel(1, 8'd2, 0);
      wait_idle(1);
      push_exp(1, 2);
      push_pixel(1, 8'd2, 0);
      push_pixel(1, 8'd2, 1);
      push_pixel(1, 8'd3, 0);
      wait_idle(1);

      // FRAME_PIXELS=1: each pixel is its own mean
      push_exp(2, 200);
      push_pixel(2, 8'd200, 0);
      push_exp(2, 0);
      push_pixel(2, 8'd0, 0);
      push_exp(2, 255);
      push_pixel(2, 8'd255, 0);
      wait_idle(2);

      // 50 frames with random request gaps and random send_ack
      ack_mode = 2;
      for (int f = 0; f < 50; f++) begin
         s = 0;
         for (int i = 0; i < 4; i++) begin
            frame[i] = int'($urandom_range(0, 255));
            s += frame[i];
         end
         push_exp(0, s / 4);
         for (int i = 0; i < 4; i++) push_pixel(0, 8'(frame[i]), int'($urandom_range(0, 2)));
      end
      wait_idle(0);
      ack_mode = 0;
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/v_average.md
V_AVERAGE -- requirements
Module: v_average

Interface
REQ-001 Parameter FRAME_PIXELS, default 76800: pixels per frame to average (320x240), range 1..131071.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 pixel_v_in  input  8  pixel brightness, 0..255, valid while recv_req high.
REQ-005 recv_req  input  1  upstream has a pixel on pixel_v_in.
REQ-006 recv_ack  output  1  block can accept a pixel this cycle.
REQ-007 avg_v_out  output  8  frame mean brightness; this is the from_v value for the adjust stage.
REQ-008 send_req  output  1  avg_v_out holds a valid result.
REQ-009 send_ack  input  1  downstream takes the result this cycle.

Function
REQ-010 Pixel transfer SHALL occur on a rising edge where recv_req and recv_ack are both high; pixel_v_in is ignored otherwise.
REQ-011 Result transfer SHALL occur on a rising edge where send_req and send_ack are both high.
REQ-012 The FSM SHALL have states ACCUM, DIVIDE and SEND, and SHALL reset into ACCUM.
REQ-013 recv_ack SHALL be a registered output that is high exactly when state is ACCUM.
REQ-014 In ACCUM, each pixel transfer SHALL add pixel_v_in to sum (SUM_W bits) and increment count (CNT_W bits).
REQ-015 On the transfer that makes count equal FRAME_PIXELS, the FSM SHALL go to DIVIDE and clear count.
REQ-016 That final transfer's pixel SHALL be included in sum.
REQ-017 DIVIDE SHALL compute floor(sum / FRAME_PIXELS) with a restoring divider, one quotient bit per cycle, over exactly SUM_W cycles.
REQ-018 When DIVIDE completes, avg_v_out SHALL take quotient[7:0], send_req SHALL rise, and the FSM SHALL go to SEND.
REQ-019 Net latency: send_req SHALL rise SUM_W+1 edges after the edge of the final pixel transfer.
REQ-020 Quotient SHALL never exceed 255, because sum <= 255*FRAME_PIXELS; the block SHALL NOT clamp.
REQ-021 In SEND, avg_v_out and send_req SHALL hold stable until a result transfer, for any length of send_ack low.
REQ-022 On result transfer, send_req SHALL fall, sum SHALL clear, and the FSM SHALL return to ACCUM.
REQ-023 recv_ack SHALL be high on the edge after the result transfer.
REQ-024 avg_v_out SHALL keep its last value after the result transfer.
REQ-025 recv_req in DIVIDE or SEND SHALL be back-pressured by recv_ack=0; no pixel is dropped or double-counted.
REQ-026 send_ack while send_req is low SHALL be ignored.
REQ-027 For FRAME_PIXELS=1, each pixel SHALL produce a result equal to that pixel.
REQ-028 Width rules: CNT_W = clog2(FRAME_PIXELS+1); SUM_W = 8+CNT_W; all arithmetic SHALL be unsigned with no truncation before the divide.

Reset
REQ-029 Asserting reset at any time, including mid-frame, mid-DIVIDE or in SEND, SHALL immediately force: state ACCUM, sum 0, count 0, divider registers 0, avg_v_out 0, send_req 0, recv_ack 0.
REQ-030 The partial frame SHALL be discarded.
REQ-031 recv_ack SHALL rise on the first clock edge after reset deasserts.

Structure
REQ-032 Shared package v_avg_pkg SHALL hold the state enum (ACCUM, DIVIDE, SEND) and the CNT_W/SUM_W width functions.
REQ-033 The divider SHALL be sub-module v_divider, with ports: start, dividend[SUM_W], divisor[CNT_W], done pulse, quotient[SUM_W].
REQ-034 Divider latency SHALL be fixed at SUM_W cycles.
REQ-035 Total RTL SHALL be about 150-300 lines.

Verification (FRAME_PIXELS=4 unless stated)
REQ-036 Pixels 10,20,30,41 sent back-to-back -> send_req rises SUM_W+1 edges after the 4th transfer; avg_v_out = 25 (sum 101).
REQ-037 Four pixels of 255, then four of 0 -> results 255 then 0; avg_v_out holds 255 until the second result.
REQ-038 Hold send_ack low 6 cycles during SEND while recv_req=1 -> avg_v_out and send_req stable, recv_ack=0; 0 pixels counted until the transfer.
REQ-039 Pulse reset after 2 pixels, then send 8,8,8,8 -> result 8; the pre-reset pixels are excluded.
REQ-040 FRAME_PIXELS=3, pixels 1,1,2 -> avg_v_out = 1 (floor of 4/3).
REQ-041 FRAME_PIXELS=1, pixel 200 -> avg_v_out = 200.
REQ-042 Random recv_req/send_ack gaps over 50 frames -> every result matches a reference mean; no pixel lost or duplicated.
